// File: rtl/pll_rst_seq_pkg.sv
// Types and helpers shared by the PLL reset sequencer.
package pll_rst_seq_pkg;
`include "pll_rst_seq_defs.vh"

  typedef enum logic [1:0] {
    ST_PLL_RST   = `PLL_RST_SEQ_ST_PLL_RST,
    ST_WAIT_LOCK = `PLL_RST_SEQ_ST_WAIT_LOCK,
    ST_STABLE    = `PLL_RST_SEQ_ST_STABLE,
    ST_RUN       = `PLL_RST_SEQ_ST_RUN
  } state_t;

  localparam int EVT_CNT_W = `PLL_RST_SEQ_EVT_CNT_W;

  // Counter width that can hold the largest of the three phase lengths.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction
endpackage

// File: rtl/pll_rst_seq_defs.vh
// Shared state codes and event-counter width for the PLL reset sequencer.
`ifndef PLL_RST_SEQ_DEFS_VH
`define PLL_RST_SEQ_DEFS_VH
`define PLL_RST_SEQ_ST_PLL_RST   2'd0
`define PLL_RST_SEQ_ST_WAIT_LOCK 2'd1
`define PLL_RST_SEQ_ST_STABLE    2'd2
`define PLL_RST_SEQ_ST_RUN       2'd3
`define PLL_RST_SEQ_EVT_CNT_W    8
`endif

// File: rtl/pll_rst_seq_sync_2ff.sv
// Generic 1-bit two-flop synchronizer, reset value 0.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/pll_rst_seq.sv
// PLL reset sequencer: pulses pll_rst, waits for a stable lock, then releases downstream reset.
// Define PLL_RST_SEQ_LOSS_CNT_EN to add the loss_cnt output (RUN -> WAIT_LOCK events).
module pll_rst_seq
  import pll_rst_seq_pkg::*;
#(
  parameter int PLL_RST_CYCLES = 16,
  parameter int STABLE_CYCLES  = 1000,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 locked,
  input  logic                 soft_rst_req,
  output logic                 pll_rst,
  output logic                 rst_n_out,
  output logic                 ready,
  output logic [1:0]           state,
  output logic [EVT_CNT_W-1:0] retry_cnt
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
  ,
  output logic [EVT_CNT_W-1:0] loss_cnt
`endif
);
  localparam int CW = cnt_width(PLL_RST_CYCLES, STABLE_CYCLES, TIMEOUT_CYCLES);

  logic          locked_s;
  state_t        st;
  state_t        nxt;
  logic [CW-1:0] cnt;
  logic          timeout;

  sync_2ff u_sync (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .d     (locked),
    .q     (locked_s)
  );

  always_comb begin
    nxt     = st;
    timeout = 1'b0;
    if (soft_rst_req) begin
      nxt = ST_PLL_RST;
    end else begin
      case (st)
        ST_PLL_RST: begin
          if (cnt == CW'(PLL_RST_CYCLES - 1)) nxt = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (locked_s) begin
            nxt = ST_STABLE;
          end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            nxt     = ST_PLL_RST;
            timeout = 1'b1;
          end
        end
        ST_STABLE: begin
          // Any lock drop abandons the partial count; re-entry starts from zero.
          if (!locked_s) nxt = ST_WAIT_LOCK;
          else if (cnt == CW'(STABLE_CYCLES - 1)) nxt = ST_RUN;
        end
        ST_RUN: begin
          if (!locked_s) nxt = ST_WAIT_LOCK;
        end
        default: nxt = ST_PLL_RST;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      st        <= ST_PLL_RST;
      cnt       <= '0;
      pll_rst   <= 1'b1;
      rst_n_out <= 1'b0;
      ready     <= 1'b0;
      retry_cnt <= '0;
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
      loss_cnt  <= '0;
`endif
    end else begin
      st <= nxt;
      // A soft request restarts the PLL pulse even when already in PLL_RST.
      if (nxt != st || soft_rst_req) cnt <= '0;
      else if (st != ST_RUN)         cnt <= cnt + 1'b1;
      pll_rst   <= (nxt == ST_PLL_RST);
      rst_n_out <= (nxt == ST_RUN);
      ready     <= (nxt == ST_RUN);
      if (timeout && retry_cnt != '1) retry_cnt <= retry_cnt + 1'b1;
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
      if (st == ST_RUN && nxt == ST_WAIT_LOCK && loss_cnt != '1)
        loss_cnt <= loss_cnt + 1'b1;
`endif
    end
  end

  assign state = st;
endmodule
